// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the CBC decrypt slice.
package aes128_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned BLOCK_W    = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = a;
    for (int unsigned i = 1; i < 8; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    return r;
  endfunction

  // InvSBox = inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: bitwise XOR of the state with the round key.
module add_round_key
  import aes128_pkg::*;
(
  input  logic [BLOCK_W-1:0] st,
  input  logic [BLOCK_W-1:0] round_key,
  output logic [BLOCK_W-1:0] result
);

  assign result = st ^ round_key;

endmodule

// File: rtl/aes_inv_round.sv
// One combinational inverse AES round; InvMixColumns is bypassed on the last round.
module aes_inv_round
  import aes128_pkg::*;
(
  input  logic [BLOCK_W-1:0] st,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               last,
  output logic [BLOCK_W-1:0] next_st
);

  logic [BLOCK_W-1:0] sub;
  logic [BLOCK_W-1:0] ark;
  logic [BLOCK_W-1:0] mixed;

  // Byte n = column n/4, row n%4; row r rotates right by r columns.
  always_comb begin
    sub = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      int unsigned c, r, src;
      c   = n / 4;
      r   = n % 4;
      src = 4 * ((c + 4 - r) % 4) + r;
      sub[BLOCK_W-1-8*n -: 8] = inv_sbox(st[BLOCK_W-1-8*src -: 8]);
    end
  end

  add_round_key u_ark (
    .st        (sub),
    .round_key (round_key),
    .result    (ark)
  );

  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[BLOCK_W-1-32*c -: 32] = inv_mix_col(ark[BLOCK_W-1-32*c -: 32]);
    end
    next_st = last ? ark : mixed;
  end

endmodule

// File: rtl/aes128_cbc_dec_ctrl.sv
// Iterative AES-128 CBC decrypt controller: one shared inverse round, key index output.
module aes128_cbc_dec_ctrl
  import aes128_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic [3:0]         round_key_idx,
  input  logic [BLOCK_W-1:0] round_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  state_t             state, state_nx;
  logic [3:0]         rnd;
  logic [BLOCK_W-1:0] st_q, ct_hold, chain, out_q;
  logic [BLOCK_W-1:0] round_next;

  aes_inv_round u_round (
    .st        (st_q),
    .round_key (round_key),
    .last      (rnd == 4'd0),
    .next_st   (round_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    round_key_idx = 4'(NUM_ROUNDS);
    out_valid     = 1'b0;
    busy          = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !iv_load;
        if (in_valid && !iv_load) state_nx = ST_ROUND;
      end
      ST_ROUND: begin
        round_key_idx = rnd;
        busy          = 1'b1;
        if (rnd == 4'd0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        round_key_idx = 4'd0;
        out_valid     = 1'b1;
        busy          = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= '0;
      ct_hold <= '0;
      chain   <= '0;
      out_q   <= '0;
      rnd     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iv_load) begin
            chain <= iv;
          end else if (in_valid) begin
            st_q    <= in_data ^ round_key;
            ct_hold <= in_data;
            rnd     <= 4'(NUM_ROUNDS - 1);
          end
        end
        ST_ROUND: begin
          if (rnd != 4'd0) begin
            st_q <= round_next;
            rnd  <= rnd - 4'd1;
          end else begin
            out_q <= round_next ^ chain;
            chain <= ct_hold;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_aes128_cbc_dec_ctrl.sv
// Directed bench: FIPS-197 C.1 and SP800-38A CBC vectors, backpressure, iv_load and reset cases.
module tb_aes128_cbc_dec_ctrl;

  logic         clk = 1'b0;
  logic         reset, iv_load, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] iv, in_data, round_key, out_data;
  logic [3:0]   round_key_idx;
  logic [127:0] rk_tab [2][11];
  int           key_sel;
  int           n_checks = 0;
  int           n_errors = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SP_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SP_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SP_CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] SP_PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] SP_PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  always #5 clk = ~clk;

  aes128_cbc_dec_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .iv_load       (iv_load),
    .iv            (iv),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .round_key_idx (round_key_idx),
    .round_key     (round_key),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy)
  );

  // Key store: combinational read of the bench-expanded schedule.
  assign round_key = (round_key_idx <= 4'd10) ? rk_tab[key_sel][round_key_idx] : '0;

  // Forward S-box built from field inversion plus affine map, for key expansion only.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] x = 8'h01;
    for (int i = 0; i < 254; i++) x = m_mul(x, a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key, input int sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]) ^ rcon, m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        rcon = m_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_idx"}, 128'(round_key_idx), 128'd10);
  endtask

  // Accept one block, trace the key index, then hold DONE for 'hold' cycles.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input int hold, input logic poke_iv);
    in_data  = ct;
    in_valid = 1'b1;
    #1;
    check("accept_ready", 128'(in_ready), 128'd1);
    check("idx_accept", 128'(round_key_idx), 128'd10);
    tick();
    in_valid = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      check("idx_round", 128'(round_key_idx), 128'(k));
      check("busy_round", 128'(busy), 128'd1);
      check("valid_round", 128'(out_valid), 128'd0);
      iv_load = poke_iv && (k == 5);
      iv      = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      tick();
    end
    iv_load = 1'b0;
    check("done_valid", 128'(out_valid), 128'd1);
    check("done_data", out_data, pt);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      tick();
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_data", out_data, pt);
      check("hold_ready", 128'(in_ready), 128'd0);
      check("hold_idx", 128'(round_key_idx), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("release");
  endtask

  initial begin
    reset     = 1'b1;
    iv_load   = 1'b0;
    iv        = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    key_sel   = 0;
    expand(C1_KEY, 0);
    expand(SP_KEY, 1);
    tick();
    tick();
    reset = 1'b0;
    check_idle("post_reset");
    check("post_reset_data", out_data, '0);

    // FIPS-197 C.1 with chaining value 0.
    run_block(C1_CT, C1_PT, 0, 1'b0);

    // iv_load wins over in_valid in the same IDLE cycle.
    key_sel  = 1;
    iv_load  = 1'b1;
    iv       = SP_IV;
    in_valid = 1'b1;
    in_data  = SP_CT1;
    #1;
    check("ivload_ready", 128'(in_ready), 128'd0);
    tick();
    iv_load = 1'b0;
    check("ivload_busy", 128'(busy), 128'd0);
    check("ivload_idx", 128'(round_key_idx), 128'd10);

    // CBC block 1 with backpressure, block 2 with a stray iv_load mid-round.
    run_block(SP_CT1, SP_PT1, 5, 1'b0);
    run_block(SP_CT2, SP_PT2, 0, 1'b1);

    // Reset mid-block discards the block and clears the chain.
    in_data  = SP_CT1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", 128'(busy), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    check("mid_reset_data", out_data, '0);

    key_sel = 0;
    run_block(C1_CT, C1_PT, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes128_cbc_dec_ctrl.md
# aes128_cbc_dec_ctrl

Iterative AES-128 CBC decryption controller: accepts one 128-bit ciphertext block per transaction, sequences the initial add-round-key plus 10 inverse rounds over a single shared round datapath, then XORs the result with the CBC chaining value to produce plaintext. It sits between the stream interface of the CBC decryptor IP and the expanded-key store, selecting the round key each cycle through an index output.

## Interface
- NUM_ROUNDS, 10, inverse rounds per block (AES-128); round key index range NUM_ROUNDS..0
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- iv_load  in  1  load iv into chaining register (honoured in IDLE only)
- iv  in  128  initialisation vector
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  controller can accept a block
- in_data  in  128  ciphertext block
- round_key_idx  out  4  index of round key required this cycle
- round_key  in  128  key-store data for round_key_idx, same cycle (combinational read)
- out_valid  out  1  plaintext block valid
- out_ready  in  1  downstream accepts plaintext
- out_data  out  128  plaintext block
- busy  out  1  high in ROUND and DONE

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: round_key_idx = NUM_ROUNDS; in_ready = !iv_load.
  - iv_load=1: chain <= iv; in_valid ignored that cycle (iv_load wins).
  - in_valid & in_ready: st <= in_data ^ round_key; ct_hold <= in_data; rnd <= NUM_ROUNDS-1; -> ROUND.
- ROUND: round_key_idx = rnd; in_ready = 0.
  - rnd != 0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ round_key); rnd <= rnd-1.
  - rnd == 0: out_data <= InvSubBytes(InvShiftRows(st)) ^ round_key ^ chain; chain <= ct_hold; -> DONE.
- DONE: out_valid = 1; out_data stable; round_key_idx = 0. out_ready=1 -> IDLE. out_ready=0 -> hold indefinitely.
- iv_load outside IDLE: ignored; chain unchanged.
- All XORs bitwise 128-bit; byte 0 = bits [127:120] (FIPS-197 ordering).
- Reset (any state, including mid-block): state IDLE, st/ct_hold/chain/out_data = 0, rnd = 0, out_valid = 0, busy = 0; in-flight block discarded, chaining restarts from IV 0 until iv_load.

## Timing
- Accept edge E0; ROUND occupies edges E1..E10; out_valid high from after E10.
- Latency in_valid&in_ready -> out_valid: NUM_ROUNDS edges (10).
- Throughput with out_ready held high: one block per NUM_ROUNDS+2 cycles (12).
- in_ready, out_valid, busy, round_key_idx are decoded from registered state only, except in_ready's combinational dependency on iv_load.
- round_key must be valid in the same cycle as round_key_idx; no read-latency cycle.
- Post-reset outputs: in_ready = 1 (iv_load low), round_key_idx = 10, out_valid = 0, out_data = 0, busy = 0.

## Structure
- Shared package aes128_pkg: NUM_ROUNDS, state encoding (IDLE/ROUND/DONE), block-width constant 128, InvSBox table / InvMixColumns GF(2^8) helpers.
- One sub-module: aes_inv_round (combinational; inputs st, round_key, last; output next state; InvShiftRows -> InvSubBytes -> ARK -> InvMixColumns bypassed when last=1). ARK step instantiates the existing add_round_key block.
- Controller holds FSM, 4-bit rnd counter, st/ct_hold/chain/out_data registers.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, iv_load 0, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff exactly 10 edges after accept.
- SP800-38A F.2.2 CBC: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102..0f; ct 7649abac8119b246cee98e9b12e9197d -> 6bc1bee22e409f96e93d7e117393172a; then ct 5086cb9b507219ee95db113a917678b2 -> ae2d8a571e03ac9c9eb76fac45af8e51 (chain update).
- Backpressure: out_ready low 5 cycles in DONE -> out_valid/out_data stable, in_ready 0, round_key_idx 0; release -> IDLE next edge.
- iv_load and in_valid same IDLE cycle -> in_ready 0, IV loaded, block accepted next cycle; iv_load during ROUND -> chain unchanged, SP800-38A block 2 still correct.
- Reset asserted at round 5 -> next cycle IDLE, out_valid 0, in_ready 1, out_data 0; following block with IV 0 decrypts to raw AES inverse of ct.
- round_key_idx trace per block: 10,9,8,...,1,0 on consecutive cycles from accept cycle.
